counter_load_ctrl: RTL and testbench

- Upstream control stage for the 4-bit loadable counter. Drives that counter's load and load_data inputs.
- Takes a raw, asynchronous push-button and a 4-bit switch value. Synchronises and debounces the button, then issues exactly one fixed-width load pulse per press, carrying the switch value captured at that moment.
- Also keeps a running count of issued loads, for status display.

---
 rtl/counter_load_ctrl.sv | 127 ++++++++++++
 tb/tb_counter_load_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_load_ctrl.sv
// Upstream control for the loadable counter: synchronises and debounces a push-button,
// then issues one fixed-width load pulse per press carrying the switch value captured at that moment.
module counter_load_ctrl #(
  parameter int DATA_W            = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LOAD_PULSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              enable,
  output logic              load,
  output logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic [7:0]        load_count
);

  // One counter serves both the debounce windows and the pulse width.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > LOAD_PULSE_CYCLES) ? DEBOUNCE_CYCLES
                                                                 : LOAD_PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(LOAD_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    LOAD,
    WAIT_RELEASE
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic                   capture;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;

    case (state)
      IDLE: begin
        if (btn_sync && enable) begin
          state_next = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!btn_sync) begin
          state_next = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_next = LOAD;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      LOAD: begin
        if (cnt == PULSE_LAST) begin
          state_next = WAIT_RELEASE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      WAIT_RELEASE: begin
        // Any bounce back to pressed restarts the release window.
        if (btn_sync) begin
          cnt_next = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end
  end

  // load and busy are registered copies of the next-state decode, so they track state exactly
  // with no combinational path from any input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      load       <= 1'b0;
      busy       <= 1'b0;
      load_data  <= '0;
      load_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      load  <= (state_next == LOAD);
      busy  <= (state_next != IDLE);
      if (capture) begin
        load_data  <= sw_data;
        load_count <= load_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Directed bench for counter_load_ctrl: reset, clean press latency, bounce rejection,
// capture stability, enable gating, reset mid-pulse and load_count wrap.
module tb_counter_load_ctrl;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset = 1'b0;
  logic       btn_raw = 1'b0;
  logic [3:0] sw_data = 4'd0;
  logic       enable = 1'b1;
  logic       load;
  logic [3:0] load_data;
  logic       busy;
  logic [7:0] load_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  logic load_prev = 1'b0;

  counter_load_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .sw_data    (sw_data),
    .enable     (enable),
    .load       (load),
    .load_data  (load_data),
    .busy       (busy),
    .load_count (load_count)
  );

  always #5 clk = clk_run ? ~clk : clk;

  // Counts rising edges of load as seen just before each clock edge.
  always @(posedge clk) begin
    if (load === 1'b1 && load_prev !== 1'b1) pulses = pulses + 1;
    load_prev = load;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock periods, ending on a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release the button and wait out the release debounce.
  task automatic release_btn();
    btn_raw = 1'b0;
    step(20);
  endtask

  initial begin
    // Reset with the clock stopped.
    #3 reset = 1'b1;
    #1;
    check("rst_load", load, 0);
    check("rst_load_data", load_data, 0);
    check("rst_busy", busy, 0);
    check("rst_load_count", load_count, 0);

    clk_run = 1'b1;
    step(2);
    reset = 1'b0;
    p0 = pulses;
    step(50);
    check("idle_load", load, 0);
    check("idle_busy", busy, 0);
    check("idle_pulses", pulses - p0, 0);

    // Clean press, sw_data=3, held 40 cycles.
    sw_data = 4'd3;
    btn_raw = 1'b1;
    p0 = pulses;
    step(2);
    check("clean_busy_e1", busy, 0);
    step(1);
    check("clean_busy_e2", busy, 1);
    step(15);
    check("clean_load_e17", load, 0);
    step(1);
    check("clean_load_e18", load, 1);
    check("clean_data_e18", load_data, 3);
    check("clean_count", load_count, 1);
    step(1);
    check("clean_load_e19", load, 1);
    step(1);
    check("clean_load_e20", load, 0);
    check("clean_busy_wait", busy, 1);
    step(19);
    check("clean_one_pulse", pulses - p0, 1);
    check("clean_data_hold", load_data, 3);
    btn_raw = 1'b0;
    step(17);
    check("release_busy_e16", busy, 1);
    step(1);
    check("release_busy_e17", busy, 0);
    step(3);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold.
    sw_data = 4'd7;
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      step(3);
    end
    check("bounce_no_pulse", pulses - p0, 0);
    btn_raw = 1'b1;
    step(18);
    check("bounce_load_e17", load, 0);
    step(1);
    check("bounce_load_e18", load, 1);
    check("bounce_data", load_data, 7);
    step(30);
    check("bounce_one_pulse", pulses - p0, 1);
    check("bounce_count", load_count, 2);
    release_btn();

    // sw_data changes during the pulse.
    sw_data = 4'd5;
    btn_raw = 1'b1;
    step(19);
    check("swchg_load", load, 1);
    check("swchg_data_e18", load_data, 5);
    sw_data = 4'd9;
    step(1);
    check("swchg_data_e19", load_data, 5);
    step(1);
    check("swchg_load_end", load, 0);
    release_btn();
    check("swchg_data_idle", load_data, 5);
    btn_raw = 1'b1;
    step(19);
    check("swchg_next_data", load_data, 9);
    check("swchg_count", load_count, 4);
    release_btn();

    // Gating: enable low for a full press.
    enable = 1'b0;
    btn_raw = 1'b1;
    p0 = pulses;
    step(5);
    check("gate_busy_early", busy, 0);
    step(35);
    check("gate_busy_late", busy, 0);
    check("gate_no_pulse", pulses - p0, 0);
    check("gate_count", load_count, 4);
    release_btn();

    // enable dropped during DEBOUNCE does not abort the press.
    enable = 1'b1;
    sw_data = 4'd12;
    btn_raw = 1'b1;
    step(5);
    check("gate_mid_busy", busy, 1);
    enable = 1'b0;
    step(14);
    check("gate_mid_load", load, 1);
    check("gate_mid_data", load_data, 12);
    check("gate_mid_count", load_count, 5);
    release_btn();
    enable = 1'b1;

    // Reset mid-pulse: load drops without waiting for a clock edge.
    sw_data = 4'd6;
    btn_raw = 1'b1;
    step(19);
    check("rstp_load_before", load, 1);
    reset = 1'b1;
    #1;
    check("rstp_load", load, 0);
    check("rstp_count", load_count, 0);
    check("rstp_busy", busy, 0);
    check("rstp_data", load_data, 0);
    btn_raw = 1'b0;
    step(2);
    reset = 1'b0;
    step(5);

    // 256 clean presses wrap load_count back to 0.
    p0 = pulses;
    for (int i = 0; i < 256; i++) begin
      sw_data = 4'(i);
      btn_raw = 1'b1;
      step(21);
      if (i == 0) check("wrap_first", load_count, 1);
      if (i == 254) check("wrap_255", load_count, 255);
      release_btn();
    end
    check("wrap_zero", load_count, 0);
    check("wrap_pulses", pulses - p0, 256);
    check("wrap_data", load_data, 15);
    check("wrap_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
